// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin selection among functional-unit results,
// combinational yumi back to the winner, registered one-cycle CDB broadcast.
module cdb_arbiter #(
    parameter  int NUM_FU = 4,
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 6,
    localparam int PTR_W  = $clog2(NUM_FU)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_FU-1:0]        fu_valid_i,
    input  logic [NUM_FU*DATA_W-1:0] fu_data_i,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag_i,
    output logic [NUM_FU-1:0]        fu_yumi_o,
    input  logic                     cdb_stall_i,
    input  logic                     flush_i,
    output logic                     cdb_valid_o,
    output logic [DATA_W-1:0]        cdb_data_o,
    output logic [TAG_W-1:0]         cdb_tag_o,
    output logic [PTR_W-1:0]         cdb_src_o
);

    // Handshake: a unit's result is consumed in exactly the cycle where its
    // valid and its yumi bit are both high; yumi never rises without valid.

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [PTR_W-1:0]  cdb_src_q, cdb_src_d;

    logic [DATA_W-1:0] data_arr [NUM_FU];
    logic [TAG_W-1:0]  tag_arr  [NUM_FU];
    logic              en;
    logic              found;
    logic              grant;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  idx;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            data_arr[i] = fu_data_i[i*DATA_W +: DATA_W];
            tag_arr[i]  = fu_tag_i[i*TAG_W +: TAG_W];
        end
    end

    // Scan starts at the pointer and wraps, so the most recently served unit
    // is considered last.
    always_comb begin
        en    = !reset_i && !cdb_stall_i && !flush_i;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % NUM_FU);
            if (!found && fu_valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grant = en && found;
    end

    always_comb begin
        fu_yumi_o = '0;
        if (grant) begin
            fu_yumi_o[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        cdb_valid_d = grant;
        cdb_data_d  = cdb_data_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        if (grant) begin
            ptr_d      = (int'(win) == NUM_FU - 1) ? '0 : win + PTR_W'(1);
            cdb_data_d = data_arr[win];
            cdb_tag_d  = tag_arr[win];
            cdb_src_d  = win;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid_o = cdb_valid_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_src_o   = cdb_src_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter and broadcaster that sits at the consuming end of the functional-unit output handshake (valid / yumi). Each cycle it selects one valid functional-unit result by round-robin, asserts yumi back to that unit, and registers the result onto the CDB for one cycle so the ROB and reservation stations can capture it. It is the sole consumer of every functional-unit output stage.

## Interface
Parameters:
- NUM_FU, 4: number of functional-unit result ports; must be ≥2.
- DATA_W, 32: result data width.
- TAG_W, 6: ROB tag width.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- fu_valid_i  input  NUM_FU  bit i set means FU i holds a result.
- fu_data_i  input  NUM_FU*DATA_W  FU i data in bits [i*DATA_W +: DATA_W].
- fu_tag_i  input  NUM_FU*TAG_W  FU i ROB tag in bits [i*TAG_W +: TAG_W].
- fu_yumi_o  output  NUM_FU  one-hot or zero; bit i means FU i's result is consumed this cycle.
- cdb_stall_i  input  1  downstream cannot take a broadcast next cycle; no grant this cycle.
- flush_i  input  1  pipeline flush; no grant this cycle, kills the pending broadcast.
- cdb_valid_o  output  1  broadcast valid (registered).
- cdb_data_o  output  DATA_W  broadcast data (registered).
- cdb_tag_o  output  TAG_W  broadcast ROB tag (registered).
- cdb_src_o  output  $clog2(NUM_FU)  index of the FU that produced the broadcast (registered).

## Operation
- State: round-robin pointer `ptr` (width $clog2(NUM_FU), reset 0) and the CDB output register.
- Grant enable `en = !reset_i && !cdb_stall_i && !flush_i`.
- Winner: the first index w scanning ptr, ptr+1, …, NUM_FU-1, 0, …, ptr-1 (mod NUM_FU) with fu_valid_i[w]=1.
- fu_yumi_o is combinational. It equals one-hot(w) when en is high and any fu_valid_i bit is set; otherwise it is 0.
- yumi is asserted only for a unit whose valid is high in the same cycle. It is never asserted speculatively.
- On a grant at edge k:
  - cdb_valid_o=1, cdb_data_o=fu_data_i[w], cdb_tag_o=fu_tag_i[w], cdb_src_o=w.
  - ptr is set to (w+1) mod NUM_FU. The wrap goes from NUM_FU-1 to 0.
- With no grant: cdb_valid_o=0 at the next edge, and data, tag and src hold their last values.
- ptr is unchanged on any cycle with no grant.
- flush_i has priority over cdb_stall_i. Both suppress the grant. flush_i also forces cdb_valid_o=0 at the next edge.
- A unit that is not granted keeps its valid and data. The arbiter imposes no timeout.
- Starvation bound: a continuously valid FU is granted within NUM_FU grant cycles.

## Timing
- Reset values: cdb_valid_o=0, cdb_data_o=0, cdb_tag_o=0, cdb_src_o=0, ptr=0.
- fu_yumi_o=0 in every cycle where reset_i=1.
- Reset asserted in the middle of operation takes effect at the next edge. No broadcast is produced from the reset cycle.
- Latency: a grant (yumi) in cycle k produces cdb_valid_o in cycle k+1.
- cdb_valid_o is a single-cycle pulse per grant. There is no downstream backpressure on an issued broadcast; stall only blocks new grants.
- Throughput: one broadcast per cycle when en stays high and some FU is valid.
- Combinational paths: fu_valid_i, cdb_stall_i, flush_i and reset_i drive fu_yumi_o. No path runs from fu_data_i or fu_tag_i to any output in the same cycle.
- Simultaneous events: only one FU is granted when several are valid. A producer that refills in the same cycle it receives yumi is allowed; its new result competes in the next cycle.

## Test plan
- Reset then idle:
  - Stimulus: hold reset_i for 2 cycles with all fu_valid_i=1.
  - Required response: fu_yumi_o=0 throughout; cdb_valid_o=0 and all outputs 0 one cycle after release.
- Single grant:
  - Stimulus: FU2 valid with data=0xDEADBEEF, tag=0x15.
  - Required response: fu_yumi_o=4'b0100 that cycle; next cycle cdb_valid_o=1, data=0xDEADBEEF, tag=0x15, src=2; ptr=3.
- Round-robin fairness:
  - Stimulus: all four FUs continuously valid from reset.
  - Required response: grants 0,1,2,3,0,1 on consecutive cycles; cdb_src_o follows one cycle later.
- Wrap and skip:
  - Stimulus: ptr=3, only FU1 and FU3 valid.
  - Required response: grant FU3, then ptr=0 and the next grant is FU1.
- Stall and flush:
  - Stimulus: FU0 valid with cdb_stall_i=1 for 3 cycles.
  - Required response: no yumi and cdb_valid_o=0 during those cycles; the grant happens in the first unstalled cycle.
  - Stimulus: flush_i=1 with stall=0 and FU1 valid.
  - Required response: no yumi, and cdb_valid_o=0 at the next edge.
- Random stress:
  - Stimulus: random valid, stall and flush against producer models that hold data until yumi.
  - Required response: the scoreboard shows every produced tag broadcast exactly once, yumi is never asserted without valid, and wait time never exceeds NUM_FU grants.
